// File: rtl/mod_key_expansion_pkg.sv
// Shared types, constants and S-box/round-constant lookups for the AES-256 key schedule.
package mod_key_expansion_pkg;

  localparam int NK       = 8;
  localparam int NW       = 60;
  localparam int NUM_RK   = 15;
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } kx_state_t;

  // Entry 0x00 sits in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] r);
    case (r)
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mod_key_expansion_if.sv
// Key load, status and round-key read bus between the key schedule and its consumer.
interface mod_key_expansion_if;

  logic                                       key_valid;
  logic [255:0]                               key_in;
  logic                                       busy;
  logic                                       ready;
  logic [mod_key_expansion_pkg::RK_IDX_W-1:0] rd_idx;
  logic [7:0] k0, k1, k2, k3, k4, k5, k6, k7;
  logic [7:0] k8, k9, k10, k11, k12, k13, k14, k15;

  modport master (
    output key_valid, key_in, rd_idx,
    input  busy, ready,
    input  k0, k1, k2, k3, k4, k5, k6, k7, k8, k9, k10, k11, k12, k13, k14, k15
  );

  modport slave (
    input  key_valid, key_in, rd_idx,
    output busy, ready,
    output k0, k1, k2, k3, k4, k5, k6, k7, k8, k9, k10, k11, k12, k13, k14, k15
  );

endinterface

// File: rtl/mod_key_expansion_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module mod_sub_word
  import mod_key_expansion_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/mod_key_expansion.sv
// AES-256 key schedule: expands a 256-bit key into 15 round keys and serves them by index.
// Optional build macro KEYEXP_SBOX_PIPE_EN registers the SubWord result (2 cycles per word).
module mod_key_expansion
  import mod_key_expansion_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mod_key_expansion_if.slave kx
);

  kx_state_t    state_r, state_s;
  logic [5:0]   cnt_r;
  logic [31:0]  win_r [0:NK-1];
  logic [127:0] rk_r  [0:NUM_RK-1];
  logic         busy_r, ready_r;
  logic [127:0] kout_r;

  logic         accept_s, step_s, last_s;
  logic [31:0]  prev_s, sub_in_s, sub_out_s, sub_use_s, temp_s, new_word_s;

`ifdef KEYEXP_SBOX_PIPE_EN
  logic         phase_r;
  logic [31:0]  sub_r;
  assign step_s    = (state_r == EXPAND) && phase_r;
  assign sub_use_s = sub_r;
`else
  assign step_s    = (state_r == EXPAND);
  assign sub_use_s = sub_out_s;
`endif

  assign last_s = (cnt_r == 6'(NW - 1));

  // Next-state decode and key acceptance
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (kx.key_valid) begin
          accept_s = 1'b1;
          state_s  = EXPAND;
        end else begin
          state_s  = state_r;
        end
      end
      EXPAND: begin
        if (step_s && last_s) begin
          state_s = DONE;
        end else begin
          state_s = EXPAND;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // RotWord only on multiples of 8; the window is stable across both pipe phases
  always_comb begin
    prev_s = win_r[NK-1];
    if (cnt_r[2:0] == 3'd0) begin
      sub_in_s = {prev_s[23:0], prev_s[31:24]};
    end else begin
      sub_in_s = prev_s;
    end
  end

  mod_sub_word u_sub_word (
    .word_in  (sub_in_s),
    .word_out (sub_out_s)
  );

  // New schedule word from w[i-8] and the transformed w[i-1]
  always_comb begin
    case (cnt_r[2:0])
      3'd0:    temp_s = sub_use_s ^ {rcon(cnt_r[5:3]), 24'h000000};
      3'd4:    temp_s = sub_use_s;
      default: temp_s = prev_s;
    endcase
    new_word_s = win_r[0] ^ temp_s;
  end

  // Word counter, sliding window and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 6'(NK);
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
      phase_r <= 1'b0;
      sub_r   <= 32'h00000000;
`endif
    end else if (accept_s) begin
      cnt_r   <= 6'(NK);
      busy_r  <= 1'b1;
      ready_r <= 1'b0;
      for (int j = 0; j < NK; j++) begin
        win_r[j] <= kx.key_in[255 - 32*j -: 32];
      end
`ifdef KEYEXP_SBOX_PIPE_EN
      phase_r <= 1'b0;
`endif
    end else if (step_s) begin
      for (int j = 0; j < NK - 1; j++) begin
        win_r[j] <= win_r[j+1];
      end
      win_r[NK-1] <= new_word_s;
`ifdef KEYEXP_SBOX_PIPE_EN
      phase_r <= 1'b0;
`endif
      if (last_s) begin
        busy_r  <= 1'b0;
        ready_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + 6'd1;
      end
    end
`ifdef KEYEXP_SBOX_PIPE_EN
    else if (state_r == EXPAND) begin
      phase_r <= 1'b1;
      sub_r   <= sub_out_s;
    end
`endif
  end

  // Key RAM: rows 0/1 load with the key, then one lane per expanded word; never cleared
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept_s) begin
        rk_r[0] <= kx.key_in[255:128];
        rk_r[1] <= kx.key_in[127:0];
      end else if (step_s) begin
        rk_r[cnt_r[5:2]][{~cnt_r[1:0], 5'b00000} +: 32] <= new_word_s;
      end
    end
  end

  // Registered read port, zero unless complete and in range
  always_ff @(posedge clk) begin
    if (rst) begin
      kout_r <= 128'd0;
    end else if (ready_r && (kx.rd_idx < 4'(NUM_RK))) begin
      kout_r <= rk_r[kx.rd_idx];
    end else begin
      kout_r <= 128'd0;
    end
  end

  assign kx.busy  = busy_r;
  assign kx.ready = ready_r;
  assign {kx.k0, kx.k1, kx.k2,  kx.k3,  kx.k4,  kx.k5,  kx.k6,  kx.k7,
          kx.k8, kx.k9, kx.k10, kx.k11, kx.k12, kx.k13, kx.k14, kx.k15} = kout_r;

endmodule

// File: tb/tb_mod_key_expansion.sv
// Self-checking bench: cycle-level behavioural model with an independent GF(2^8) S-box.
module tb_mod_key_expansion;

`ifdef KEYEXP_SBOX_PIPE_EN
  localparam int LAT = 104;
`else
  localparam int LAT = 52;
`endif

  logic clk;
  logic rst;
  mod_key_expansion_if kx();

  mod_key_expansion dut (.clk(clk), .rst(rst), .kx(kx));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic           m_busy    = 1'b0;
  logic           m_ready   = 1'b0;
  int             m_cnt     = 0;
  logic [1919:0]  m_pending = '0;
  logic [1919:0]  m_sched   = '0;
  logic [127:0]   m_k       = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = b;
    logic [7:0] s;
    for (int e = 254; e > 0; e = e >> 1) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  // Round key r occupies bits [r*128 +: 128]
  function automatic logic [1919:0] expand(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] s;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) s[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [127:0] kcat();
    return {kx.k0, kx.k1, kx.k2,  kx.k3,  kx.k4,  kx.k5,  kx.k6,  kx.k7,
            kx.k8, kx.k9, kx.k10, kx.k11, kx.k12, kx.k13, kx.k14, kx.k15};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: key accepted when idle/done, schedule becomes visible LAT edges later
  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_k     <= '0;
    end else begin
      if (m_ready && kx.rd_idx < 4'd15) m_k <= m_sched[int'(kx.rd_idx)*128 +: 128];
      else                              m_k <= '0;
      if (!m_busy && kx.key_valid) begin
        m_busy    <= 1'b1;
        m_ready   <= 1'b0;
        m_cnt     <= LAT;
        m_pending <= expand(kx.key_in);
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
          m_sched <= m_pending;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 128'(kx.busy), 128'(m_busy));
      chk("ready", 128'(kx.ready), 128'(m_ready));
      chk("kout", kcat(), m_k);
    end
  end

  task automatic load_and_wait(input logic [255:0] key, input bit inject, output int lat);
    @(negedge clk);
    kx.key_valid = 1'b1;
    kx.key_in    = key;
    @(negedge clk);
    kx.key_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 400 && lat == 0; n++) begin
      if (inject && n == 20) begin
        kx.key_valid = 1'b1;
        kx.key_in    = '0;
      end else begin
        kx.key_valid = 1'b0;
      end
      @(negedge clk);
      if (kx.ready === 1'b1) lat = n;
    end
    kx.key_valid = 1'b0;
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    @(negedge clk);
    kx.rd_idx = idx;
    @(negedge clk);
    val = kcat();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0]  key_a3;
    logic [1919:0] sched_a3;
    logic [127:0]  val;
    int            lat;

    key_a3 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    rst = 1'b1;
    kx.key_valid = 1'b0;
    kx.key_in    = '0;
    kx.rd_idx    = 4'd0;

    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 128'(kx.busy), 128'd0);
    chk("reset_ready", 128'(kx.ready), 128'd0);
    chk("reset_k", kcat(), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Pin the model itself against published values
    chk("model_sbox_00", 128'(sbox_ref(8'h00)), 128'h63);
    chk("model_sbox_53", 128'(sbox_ref(8'h53)), 128'hed);
    sched_a3 = expand(key_a3);
    chk("model_rk0", sched_a3[0*128 +: 128], 128'h603deb10_15ca71be_2b73aef0_857d7781);
    chk("model_rk2", sched_a3[2*128 +: 128], 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
    chk("model_rk14", sched_a3[14*128 +: 128], 128'hfe4890d1_e6188d0b_046df344_706c631e);

    // A.3 key with an ignored zero-key pulse mid-expansion
    load_and_wait(key_a3, 1'b1, lat);
    chk("latency_a3", 128'(lat), 128'(LAT));
    read_rk(4'd2, val);
    chk("a3_rk2", val, 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
    read_rk(4'd14, val);
    chk("a3_rk14", val, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    read_rk(4'd0, val);
    chk("a3_rk0", val, 128'h603deb10_15ca71be_2b73aef0_857d7781);
    read_rk(4'd15, val);
    chk("idx15_zero", val, 128'd0);

    // Rekey while ready
    @(negedge clk);
    kx.key_valid = 1'b1;
    kx.key_in    = rnd256();
    @(negedge clk);
    kx.key_valid = 1'b0;
    chk("rekey_ready_drop", 128'(kx.ready), 128'd0);
    chk("rekey_busy", 128'(kx.busy), 128'd1);
    for (int n = 0; n < 200 && kx.ready !== 1'b1; n++) @(negedge clk);
    chk("rekey_done", 128'(kx.ready), 128'd1);

    // Abort mid-expansion with reset, then load the all-zero key
    @(negedge clk);
    kx.key_valid = 1'b1;
    kx.key_in    = rnd256();
    @(negedge clk);
    kx.key_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(kx.busy), 128'd0);
    chk("abort_ready", 128'(kx.ready), 128'd0);
    chk("abort_k", kcat(), 128'd0);
    load_and_wait(256'd0, 1'b0, lat);
    chk("latency_zero", 128'(lat), 128'(LAT));
    read_rk(4'd1, val);
    chk("zero_rk1", val, 128'd0);

    // Randomized keys, rekeys, ignored requests and read indices
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      kx.key_valid = ($urandom_range(39) == 0);
      kx.key_in    = rnd256();
      kx.rd_idx    = 4'($urandom_range(15));
    end
    kx.key_valid = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      kx.rd_idx = 4'($urandom_range(15));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
